// File: rtl/im_arith_unit_if.sv
// Bus bundle between the image arithmetic unit and its controller / BRAM ports.
interface im_arith_unit_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 14
);
  logic              start;
  logic              hold;
  logic [1:0]        mode;
  logic [7:0]        alpha;
  logic              busy;
  logic              done;
  logic              ena_a;
  logic              ena_b;
  logic [ADDR_W-1:0] addr_rd;
  logic [PIX_W-1:0]  dout_a;
  logic [PIX_W-1:0]  dout_b;
  logic              ena_c;
  logic              wea_c;
  logic [ADDR_W-1:0] addr_wr;
  logic [PIX_W-1:0]  din_c;

  modport master (
    output start, hold, mode, alpha, dout_a, dout_b,
    input  busy, done, ena_a, ena_b, addr_rd, ena_c, wea_c, addr_wr, din_c
  );

  modport slave (
    input  start, hold, mode, alpha, dout_a, dout_b,
    output busy, done, ena_a, ena_b, addr_rd, ena_c, wea_c, addr_wr, din_c
  );
endinterface

// File: rtl/im_arith_unit.sv
// Per-pixel arithmetic over two source images (A, B) into a destination image C.
module im_arith_unit #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned N_PIX  = 16384,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  im_arith_unit_if.slave bus
);

  localparam int unsigned CALC_W = PIX_W + 9;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_CALC, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PIX_W-1:0]  res_q, res_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        alpha_q, alpha_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ena_ab_q, ena_ab_d;
  logic              ena_c_q, ena_c_d;
  logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;
  logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
  logic [PIX_W-1:0]  din_c_q, din_c_d;

  logic [PIX_W:0]    sum_c;
  logic [CALC_W-1:0] blend_c;
  logic [PIX_W-1:0]  calc_c;

  // Pixel operation selected by the mode latched at frame start.
  always_comb begin
    sum_c   = {1'b0, bus.dout_a} + {1'b0, bus.dout_b};
    blend_c = CALC_W'(bus.dout_a) * CALC_W'(alpha_q)
            + CALC_W'(bus.dout_b) * CALC_W'(9'd256 - {1'b0, alpha_q});
    calc_c  = '0;
    case (mode_q)
      2'd0:    calc_c = PIX_W'(sum_c >> 1);
      2'd1:    calc_c = sum_c[PIX_W] ? '1 : sum_c[PIX_W-1:0];
      2'd2:    calc_c = (bus.dout_a >= bus.dout_b) ? (bus.dout_a - bus.dout_b)
                                                   : (bus.dout_b - bus.dout_a);
      default: calc_c = PIX_W'(blend_c >> 8);
    endcase
  end

  // Next-state, datapath and next-output logic; hold freezes everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    mode_d  = mode_q;
    alpha_d = alpha_q;
    if (!bus.hold) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_d  = bus.mode;
            alpha_d = bus.alpha;
            idx_d   = '0;
            state_d = S_READ;
          end
        end
        S_READ: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = S_CALC;
          else                             cnt_d   = cnt_q + CNT_W'(1);
        end
        S_CALC: begin
          res_d   = calc_c;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == ADDR_W'(N_PIX - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
        S_DONE: begin
          if (!bus.start) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d    = (state_d == S_READ) || (state_d == S_WAIT) ||
                (state_d == S_CALC) || (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
    ena_ab_d  = (state_d == S_READ);
    ena_c_d   = (state_d == S_WRITE);
    addr_rd_d = idx_d;
    addr_wr_d = idx_d;
    din_c_d   = res_d;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      mode_q    <= '0;
      alpha_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ena_ab_q  <= 1'b0;
      ena_c_q   <= 1'b0;
      addr_rd_q <= '0;
      addr_wr_q <= '0;
      din_c_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      mode_q    <= mode_d;
      alpha_q   <= alpha_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ena_ab_q  <= ena_ab_d;
      ena_c_q   <= ena_c_d;
      addr_rd_q <= addr_rd_d;
      addr_wr_q <= addr_wr_d;
      din_c_q   <= din_c_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ena_a   = ena_ab_q;
  assign bus.ena_b   = ena_ab_q;
  assign bus.addr_rd = addr_rd_q;
  assign bus.ena_c   = ena_c_q;
  assign bus.wea_c   = ena_c_q;
  assign bus.addr_wr = addr_wr_q;
  assign bus.din_c   = din_c_q;

endmodule

// File: tb/tb_im_arith_unit.sv
// Scoreboard bench: two units (read latency 1 and 3) on 4-pixel images.
module tb_im_arith_unit;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned NP     = 4;

  typedef struct {
    int addr;
    int data;
    int k;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  im_arith_unit_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus1 ();
  im_arith_unit_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus3 ();

  im_arith_unit #(.PIX_W(PIX_W), .N_PIX(NP), .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  im_arith_unit #(.PIX_W(PIX_W), .N_PIX(NP), .ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3));

  logic [7:0] a1 [NP];
  logic [7:0] b1 [NP];
  logic [7:0] c1 [NP];
  logic [7:0] a3 [NP];
  logic [7:0] b3 [NP];
  logic [7:0] c3 [NP];
  logic [7:0] pa1, pb1;
  logic [7:0] pa3 [3];
  logic [7:0] pb3 [3];

  // BRAM models: latency-1 and latency-3 read pipelines, one write port each.
  always @(posedge clk) begin
    if (bus1.ena_a) pa1 <= a1[bus1.addr_rd[1:0]];
    if (bus1.ena_b) pb1 <= b1[bus1.addr_rd[1:0]];
    if (bus1.ena_c && bus1.wea_c) c1[bus1.addr_wr[1:0]] <= bus1.din_c;
    if (bus3.ena_a) pa3[0] <= a3[bus3.addr_rd[1:0]];
    if (bus3.ena_b) pb3[0] <= b3[bus3.addr_rd[1:0]];
    pa3[1] <= pa3[0];
    pa3[2] <= pa3[1];
    pb3[1] <= pb3[0];
    pb3[2] <= pb3[1];
    if (bus3.ena_c && bus3.wea_c) c3[bus3.addr_wr[1:0]] <= bus3.din_c;
  end
  assign bus1.dout_a = pa1;
  assign bus1.dout_b = pb1;
  assign bus3.dout_a = pa3[2];
  assign bus3.dout_b = pb3[2];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q3[$];
  int   start1 = 0, start3 = 0, done_k1 = -1, done_k3 = -1, wr_cnt1 = 0;
  logic ena_p1 = 1'b0, busy_p1 = 1'b0, done_p1 = 1'b0;
  logic ena_p3 = 1'b0, busy_p3 = 1'b0, done_p3 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] v4(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Monitor for unit 1: frame start/done timing and write pulses vs scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ena_p1 = 1'b0; busy_p1 = 1'b0; done_p1 = 1'b0;
    end else begin
      if (bus1.busy && !busy_p1) start1 = cyc;
      if (bus1.done && !done_p1) done_k1 = cyc - start1;
      if (bus1.ena_c && !ena_p1) begin
        wr_cnt1++;
        if (q1.size() == 0) begin
          chk("wr1_unexpected_addr", int'(bus1.addr_wr), -1);
        end else begin
          e = q1.pop_front();
          chk("wr1_addr", int'(bus1.addr_wr), e.addr);
          chk("wr1_data", int'(bus1.din_c), e.data);
          chk("wr1_cycle", cyc - start1 + 1, e.k);
          chk("wr1_wea", int'(bus1.wea_c), 1);
        end
      end
      ena_p1 = bus1.ena_c; busy_p1 = bus1.busy; done_p1 = bus1.done;
    end
  end

  // Monitor for unit 3.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ena_p3 = 1'b0; busy_p3 = 1'b0; done_p3 = 1'b0;
    end else begin
      if (bus3.busy && !busy_p3) start3 = cyc;
      if (bus3.done && !done_p3) done_k3 = cyc - start3;
      if (bus3.ena_c && !ena_p3) begin
        if (q3.size() == 0) begin
          chk("wr3_unexpected_addr", int'(bus3.addr_wr), -1);
        end else begin
          e = q3.pop_front();
          chk("wr3_addr", int'(bus3.addr_wr), e.addr);
          chk("wr3_data", int'(bus3.din_c), e.data);
          chk("wr3_cycle", cyc - start3 + 1, e.k);
        end
      end
      ena_p3 = bus3.ena_c; busy_p3 = bus3.busy; done_p3 = bus3.done;
    end
  end

  // One frame on unit 1; hd>0 inserts a hold of hd cycles during the first WAIT.
  task automatic frame1(input int md, input int al, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ev, input int hd);
    exp_t e;
    int   n;
    for (int i = 0; i < 4; i++) begin
      a1[i] = av[8*i +: 8];
      b1[i] = bv[8*i +: 8];
      e.addr = i; e.data = int'(ev[8*i +: 8]); e.k = 4 * (i + 1) + hd;
      q1.push_back(e);
    end
    bus1.mode = 2'(md); bus1.alpha = 8'(al); bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.mode = 2'(md + 1); bus1.alpha = 8'(al + 37);
    if (hd > 0) begin
      @(posedge clk); #1;
      bus1.hold = 1'b1;
      repeat (hd) @(posedge clk);
      #1 bus1.hold = 1'b0;
    end
    n = 0;
    while (!bus1.done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done1_seen", int'(bus1.done), 1);
    @(negedge clk); #1;
    chk("done1_cycle", done_k1, 16 + hd);
    chk("busy1_at_done", int'(bus1.busy), 0);
    repeat (3) @(posedge clk);
    #1 chk("done1_held", int'(bus1.done), 1);
    chk("busy1_held", int'(bus1.busy), 0);
    bus1.start = 1'b0;
    @(posedge clk); #1;
    chk("done1_cleared", int'(bus1.done), 0);
    chk("q1_drained", q1.size(), 0);
  endtask

  // One frame on unit 3 (read latency 3).
  task automatic frame3(input int md, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ev);
    exp_t e;
    int   n;
    for (int i = 0; i < 4; i++) begin
      a3[i] = av[8*i +: 8];
      b3[i] = bv[8*i +: 8];
      e.addr = i; e.data = int'(ev[8*i +: 8]); e.k = 6 * (i + 1);
      q3.push_back(e);
    end
    bus3.mode = 2'(md); bus3.alpha = 8'd0; bus3.start = 1'b1;
    n = 0;
    while (!bus3.done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done3_seen", int'(bus3.done), 1);
    @(negedge clk); #1;
    chk("done3_cycle", done_k3, 24);
    bus3.start = 1'b0;
    @(posedge clk); #1;
    chk("done3_cleared", int'(bus3.done), 0);
    chk("q3_drained", q3.size(), 0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    bus1.start = 1'b0; bus1.hold = 1'b0; bus1.mode = 2'd0; bus1.alpha = 8'd0;
    bus3.start = 1'b0; bus3.hold = 1'b0; bus3.mode = 2'd0; bus3.alpha = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus1.busy), 0);
    chk("rst_done", int'(bus1.done), 0);
    chk("rst_ena_a", int'(bus1.ena_a), 0);
    chk("rst_ena_c", int'(bus1.ena_c), 0);
    chk("rst_addr_rd", int'(bus1.addr_rd), 0);
    chk("rst_din_c", int'(bus1.din_c), 0);
    chk("rst_busy3", int'(bus3.busy), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Mode 0 average on both latencies in parallel.
    fork
      frame1(0, 0, v4(10, 255, 0, 7), v4(20, 255, 1, 8), v4(15, 255, 0, 7), 0);
      frame3(0, v4(10, 255, 0, 7), v4(20, 255, 1, 8), v4(15, 255, 0, 7));
    join
    // Saturating add, absolute difference, blends.
    frame1(1, 0, v4(200, 100, 255, 0), v4(100, 100, 1, 0), v4(255, 200, 255, 0), 0);
    frame1(2, 0, v4(5, 9, 77, 0), v4(9, 5, 77, 255), v4(4, 4, 0, 255), 0);
    frame1(3, 64, v4(200, 0, 255, 10), v4(100, 255, 0, 10), v4(125, 191, 63, 10), 0);
    frame1(3, 0, v4(200, 0, 255, 10), v4(100, 255, 0, 10), v4(100, 255, 0, 10), 0);

    // Hold for 5 cycles in WAIT: same data, shifted by 5, exactly 4 writes.
    wr_cnt1 = 0;
    frame1(0, 0, v4(10, 255, 0, 7), v4(20, 255, 1, 8), v4(15, 255, 0, 7), 5);
    chk("hold_write_count", wr_cnt1, 4);
    chk("hold_c0", int'(c1[0]), 15);
    chk("hold_c1", int'(c1[1]), 255);
    chk("hold_c2", int'(c1[2]), 0);
    chk("hold_c3", int'(c1[3]), 7);

    // Reset while index 2 is in WAIT: only indices 0 and 1 get written.
    a1[0] = 8'd200; a1[1] = 8'd100; a1[2] = 8'd255; a1[3] = 8'd0;
    b1[0] = 8'd100; b1[1] = 8'd100; b1[2] = 8'd1;   b1[3] = 8'd0;
    e.addr = 0; e.data = 255; e.k = 4; q1.push_back(e);
    e.addr = 1; e.data = 200; e.k = 8; q1.push_back(e);
    bus1.mode = 2'd1; bus1.start = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    bus1.start = 1'b0;
    #1;
    chk("midrst_busy", int'(bus1.busy), 0);
    chk("midrst_ena_a", int'(bus1.ena_a), 0);
    chk("midrst_ena_c", int'(bus1.ena_c), 0);
    chk("midrst_addr_rd", int'(bus1.addr_rd), 0);
    chk("midrst_addr_wr", int'(bus1.addr_wr), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_q_drained", q1.size(), 0);
    chk("midrst_idle_busy", int'(bus1.busy), 0);

    // Fresh start after reset rewrites from index 0.
    frame1(2, 0, v4(5, 9, 77, 0), v4(9, 5, 77, 255), v4(4, 4, 0, 255), 0);
    chk("restart_c0", int'(c1[0]), 4);
    chk("restart_c3", int'(c1[3]), 255);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
